// File: rtl/prf_pkg.sv
// Shared sizing constants and types for the physical register file.
package prf_pkg;

  localparam int NUM_REGS = 32;
  localparam int WIDTH    = 16;
  localparam int TAG_W    = 5;
  localparam int ZERO_REG = 1;

  typedef logic [TAG_W-1:0] prf_tag_t;
  typedef logic [WIDTH-1:0] prf_data_t;

endpackage

// File: rtl/prf_storage.sv
// Physical register array: one write port, one combinational read port.
// Out-of-range tags neither write nor read (reads return 0).
module prf_storage #(
  parameter int NUM_REGS = prf_pkg::NUM_REGS,
  parameter int WIDTH    = prf_pkg::WIDTH,
  parameter int TAG_W    = prf_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [TAG_W-1:0] wtag,
  input  logic [WIDTH-1:0] wdata,
  input  logic [TAG_W-1:0] rtag,
  output logic [WIDTH-1:0] rdata
);
  import prf_pkg::*;

  logic [WIDTH-1:0] regs [NUM_REGS];

  // Decoded write keeps tags beyond the array from aliasing onto real entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == int'(wtag)) regs[i] <= wdata;
      end
    end
  end

  assign rdata = (int'(rtag) < NUM_REGS) ? regs[rtag] : '0;

endmodule

// File: rtl/prf_read_port.sv
// Read side of the physical register file: tagged requests, 1-cycle latency,
// same-cycle write bypass and a single response slot held under back-pressure.
module prf_read_port #(
  parameter int NUM_REGS = prf_pkg::NUM_REGS,
  parameter int WIDTH    = prf_pkg::WIDTH,
  parameter int TAG_W    = prf_pkg::TAG_W,
  parameter int ZERO_REG = prf_pkg::ZERO_REG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req_valid,
  input  logic [TAG_W-1:0] rd_req_tag,
  output logic             rd_req_ready,
  output logic             rd_rsp_valid,
  output logic [WIDTH-1:0] rd_rsp_data,
  output logic [TAG_W-1:0] rd_rsp_tag,
  input  logic             rd_rsp_ready
);
  import prf_pkg::*;

  logic             store_we;
  logic [WIDTH-1:0] store_rdata;
  logic [WIDTH-1:0] read_value;
  logic             fire;

  assign store_we = wr_en && !((ZERO_REG != 0) && (wr_tag == '0));

  prf_storage #(
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WIDTH),
    .TAG_W    (TAG_W)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (store_we),
    .wtag  (wr_tag),
    .wdata (wr_data),
    .rtag  (rd_req_tag),
    .rdata (store_rdata)
  );

  // Zero register and out-of-range tags win over the bypass so they always read 0.
  always_comb begin
    read_value = store_rdata;
    if ((ZERO_REG != 0) && (rd_req_tag == '0)) begin
      read_value = '0;
    end else if (int'(rd_req_tag) >= NUM_REGS) begin
      read_value = '0;
    end else if (wr_en && (wr_tag == rd_req_tag)) begin
      read_value = wr_data;
    end
  end

  assign rd_req_ready = !rd_rsp_valid || rd_rsp_ready;
  assign fire         = rd_req_valid && rd_req_ready;

  // Data/tag only load on accept, so a stalled response is a frozen snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp_tag   <= '0;
    end else if (fire) begin
      rd_rsp_valid <= 1'b1;
      rd_rsp_data  <= read_value;
      rd_rsp_tag   <= rd_req_tag;
    end else if (rd_rsp_ready) begin
      rd_rsp_valid <= 1'b0;
    end
  end

endmodule
